// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: uart_core register map and FSM state encoding.
package uart_pkg;

   localparam logic [7:0] UART_ADDR_DIV    = 8'd0;
   localparam logic [7:0] UART_ADDR_TXDATA = 8'd4;
   localparam logic [7:0] UART_ADDR_TXEN   = 8'd16;

   typedef enum logic [2:0] {
      IDLE,
      WR_DIV,
      WR_DATA,
      TXEN_SET,
      TXEN_CLR,
      WAIT_DONE
   } uart_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic found;
   int   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_core transmitter among NUM_REQ byte producers by sequencing its register bus.
// Optional feature macro: UART_TX_TIMEOUT_EN (bounds the wait for intr_tx and flags err_timeout_o).
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [15:0]          cfg_div_i,
   input  logic                 cfg_update_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 uart_we_o,
   output logic                 uart_ren_o,
   output logic [7:0]           uart_addr_o,
   output logic [31:0]          uart_wdata_o,
   input  logic                 uart_intr_tx_i,
   output logic                 busy_o,
   output logic [2:0]           grant_id_o,
   output logic                 err_timeout_o,
   input  logic                 err_clr_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   uart_sched_state_e  state_q, state_d;
   logic               cfg_pending_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [7:0]         byte_q;
   logic [2:0]         grant_id_q;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               grant_en;
   logic [7:0]         grant_byte;
   logic               timeout_hit;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .req     (req_valid_i),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // A pending divisor write always takes priority over granting a byte.
   assign grant_en = (state_q == IDLE) && !cfg_pending_q && (|req_valid_i);

   always_comb begin
      grant_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            grant_byte = req_data_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cfg_pending_q) begin
               state_d = WR_DIV;
            end else if (|req_valid_i) begin
               state_d = WR_DATA;
            end
         end
         WR_DIV:    state_d = IDLE;
         WR_DATA:   state_d = TXEN_SET;
         TXEN_SET:  state_d = TXEN_CLR;
         TXEN_CLR:  state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (uart_intr_tx_i || timeout_hit) begin
               state_d = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      uart_we_o    = 1'b0;
      uart_addr_o  = 8'd0;
      uart_wdata_o = 32'd0;
      unique case (state_q)
         WR_DIV: begin
            uart_we_o    = 1'b1;
            uart_addr_o  = UART_ADDR_DIV;
            uart_wdata_o = {16'd0, cfg_div_i};
         end
         WR_DATA: begin
            uart_we_o    = 1'b1;
            uart_addr_o  = UART_ADDR_TXDATA;
            uart_wdata_o = {24'd0, byte_q};
         end
         TXEN_SET: begin
            uart_we_o    = 1'b1;
            uart_addr_o  = UART_ADDR_TXEN;
            uart_wdata_o = 32'd1;
         end
         TXEN_CLR: begin
            uart_we_o    = 1'b1;
            uart_addr_o  = UART_ADDR_TXEN;
            uart_wdata_o = 32'd0;
         end
         default: begin
            uart_we_o    = 1'b0;
            uart_addr_o  = 8'd0;
            uart_wdata_o = 32'd0;
         end
      endcase
   end

   assign uart_ren_o  = 1'b0;
   assign req_ready_o = grant_en ? arb_gnt : '0;
   assign busy_o      = (state_q != IDLE) | cfg_pending_q;
   assign grant_id_o  = grant_id_q;

   // An update arriving in the same cycle as the divisor write keeps the request pending.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_pending_q <= 1'b1;
      end else if (cfg_update_i) begin
         cfg_pending_q <= 1'b1;
      end else if (state_q == WR_DIV) begin
         cfg_pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         byte_q     <= 8'd0;
         grant_id_q <= 3'd0;
      end else if (grant_en) begin
         rr_ptr_q   <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
         byte_q     <= grant_byte;
         grant_id_q <= 3'(arb_idx);
      end
   end

`ifdef UART_TX_TIMEOUT_EN
   logic [16:0] wait_cnt_q;
   logic        err_q;

   // The counter sits at zero outside WAIT_DONE, so each wait starts counting from zero.
   assign timeout_hit = (state_q == WAIT_DONE) && !uart_intr_tx_i
                        && (wait_cnt_q == 17'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q <= 17'd0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == WAIT_DONE) ? wait_cnt_q + 17'd1 : 17'd0;
         if (timeout_hit) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end
      end
   end

   assign err_timeout_o = err_q;
`else
   logic [17:0] unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign err_timeout_o      = 1'b0;
   assign unused_timeout_cfg = {err_clr_i, 17'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed, table-driven bench for uart_tx_sched with hand-written multi-cycle corner sequences.
module tb_uart_tx_sched;

   logic        clk;
   logic        rst_n;
   logic [15:0] cfg_div;
   logic        cfg_update;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_ready;
   logic        we;
   logic        ren;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic        intr_tx;
   logic        busy;
   logic [2:0]  grant_id;
   logic        err_timeout;
   logic        err_clr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  valid;
      logic [15:0] data;
      int          expIdx;
      logic [7:0]  expByte;
      int          intrDelay;
   } vec_t;

   vec_t vecs[10];

   uart_tx_sched #(
      .NUM_REQ     (2),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .cfg_div_i      (cfg_div),
      .cfg_update_i   (cfg_update),
      .req_valid_i    (req_valid),
      .req_data_i     (req_data),
      .req_ready_o    (req_ready),
      .uart_we_o      (we),
      .uart_ren_o     (ren),
      .uart_addr_o    (addr),
      .uart_wdata_o   (wdata),
      .uart_intr_tx_i (intr_tx),
      .busy_o         (busy),
      .grant_id_o     (grant_id),
      .err_timeout_o  (err_timeout),
      .err_clr_i      (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled and inputs driven around the falling edge, away from the active edge.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [15:0] data);
      req_valid = valid;
      req_data  = data;
   endtask

   task automatic startFrame(input int expIdx, input logic [7:0] expByte);
      logic [1:0] expReady;
      expReady         = '0;
      expReady[expIdx] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (req_ready != 2'b00) break;
         @(negedge clk);
      end
      checkOutput("grant_ready", 32'(req_ready), 32'(expReady));
      @(negedge clk);
      checkOutput("data_we", 32'(we), 32'd1);
      checkOutput("data_addr", 32'(addr), 32'd4);
      checkOutput("data_wdata", wdata, {24'd0, expByte});
      checkOutput("grant_id", 32'(grant_id), 32'(expIdx));
      checkOutput("ready_after_grant", 32'(req_ready), 32'd0);
      @(negedge clk);
      checkOutput("txen_set_addr", 32'(addr), 32'd16);
      checkOutput("txen_set_wdata", wdata, 32'd1);
      @(negedge clk);
      checkOutput("txen_clr_we", 32'(we), 32'd1);
      checkOutput("txen_clr_addr", 32'(addr), 32'd16);
      checkOutput("txen_clr_wdata", wdata, 32'd0);
      @(negedge clk);
      checkOutput("wait_we", 32'(we), 32'd0);
      checkOutput("wait_busy", 32'(busy), 32'd1);
   endtask

   task automatic finishFrame(input int intrDelay, input bit pulseCfg);
      for (int k = 0; k < intrDelay; k++) begin
         cfg_update = pulseCfg && (k == 0 || k == 2);
         @(negedge clk);
         if (k == intrDelay - 1) checkOutput("still_waiting", 32'(busy), 32'd1);
      end
      cfg_update = 1'b0;
      intr_tx    = 1'b1;
      @(negedge clk);
      intr_tx = 1'b0;
      checkOutput("busy_after_intr", 32'(busy), 32'(pulseCfg));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      vecs[0] = '{2'b01, 16'h00AA, 0, 8'hAA, 10};
      vecs[1] = '{2'b10, 16'h5500, 1, 8'h55, 3};
      vecs[2] = '{2'b11, 16'h2211, 0, 8'h11, 3};
      vecs[3] = '{2'b11, 16'h2211, 1, 8'h22, 3};
      vecs[4] = '{2'b11, 16'h2211, 0, 8'h11, 3};
      vecs[5] = '{2'b11, 16'h2211, 1, 8'h22, 3};
      vecs[6] = '{2'b10, 16'h7700, 1, 8'h77, 2};
      vecs[7] = '{2'b01, 16'h0033, 0, 8'h33, 2};
      vecs[8] = '{2'b01, 16'h0044, 0, 8'h44, 1};
      vecs[9] = '{2'b11, 16'h6655, 1, 8'h66, 1};

      rst_n      = 1'b0;
      cfg_div    = 16'd87;
      cfg_update = 1'b0;
      intr_tx    = 1'b0;
      err_clr    = 1'b0;
      applyStimulus(2'b00, 16'h0000);
      repeat (2) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_we", 32'(we), 32'd0);
      checkOutput("rst_ren", 32'(ren), 32'd0);
      checkOutput("rst_addr", 32'(addr), 32'd0);
      checkOutput("rst_wdata", wdata, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd1);
      checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
      checkOutput("rst_err", 32'(err_timeout), 32'd0);

      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("div_we", 32'(we), 32'd1);
      checkOutput("div_addr", 32'(addr), 32'd0);
      checkOutput("div_wdata", wdata, 32'd87);
      @(negedge clk);
      checkOutput("div_busy_fall", 32'(busy), 32'd0);
      checkOutput("div_we_fall", 32'(we), 32'd0);

      $display("[TB] table frames");
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].valid, vecs[v].data);
         startFrame(vecs[v].expIdx, vecs[v].expByte);
         finishFrame(vecs[v].intrDelay, 1'b0);
      end

      applyStimulus(2'b00, 16'h0000);
      repeat (3) @(negedge clk);
      checkOutput("idle_ready", 32'(req_ready), 32'd0);
      checkOutput("idle_we", 32'(we), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      $display("[TB] divisor update mid-frame");
      applyStimulus(2'b10, 16'h9900);
      startFrame(1, 8'h99);
      cfg_div = 16'd43;
      finishFrame(4, 1'b1);
      #1;
      checkOutput("cfg_wins_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      checkOutput("cfg_div_we", 32'(we), 32'd1);
      checkOutput("cfg_div_addr", 32'(addr), 32'd0);
      checkOutput("cfg_div_wdata", wdata, 32'd43);
      @(negedge clk);
      #1;
      checkOutput("cfg_merged_ready", 32'(req_ready), 32'd2);
      startFrame(1, 8'h99);
      finishFrame(3, 1'b0);

      $display("[TB] reset during TXEN_SET");
      applyStimulus(2'b10, 16'hAB00);
      #1;
      checkOutput("abort_ready", 32'(req_ready), 32'd2);
      @(negedge clk);
      checkOutput("abort_grant_id", 32'(grant_id), 32'd1);
      @(negedge clk);
      checkOutput("abort_txen_set", 32'(wdata), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_we", 32'(we), 32'd0);
      checkOutput("abort_addr", 32'(addr), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd1);
      checkOutput("abort_grant_rst", 32'(grant_id), 32'd0);
      @(negedge clk);
      applyStimulus(2'b11, 16'h2233);
      rst_n = 1'b1;
      #1;
      checkOutput("abort_no_grant", 32'(req_ready), 32'd0);
      @(negedge clk);
      checkOutput("abort_div_we", 32'(we), 32'd1);
      checkOutput("abort_div_addr", 32'(addr), 32'd0);
      checkOutput("abort_div_wdata", wdata, 32'd43);
      @(negedge clk);
      startFrame(0, 8'h33);
      finishFrame(3, 1'b0);

      $display("[TB] wait without intr_tx");
      applyStimulus(2'b01, 16'h005A);
      startFrame(0, 8'h5A);
      applyStimulus(2'b00, 16'h0000);
`ifdef UART_TX_TIMEOUT_EN
      repeat (99) @(negedge clk);
      checkOutput("to_not_yet", 32'(err_timeout), 32'd0);
      checkOutput("to_busy_before", 32'(busy), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("to_set_wins", 32'(err_timeout), 32'd1);
      checkOutput("to_back_idle", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("to_sticky", 32'(err_timeout), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("to_cleared", 32'(err_timeout), 32'd0);
`else
      repeat (200) @(negedge clk);
      checkOutput("nto_busy", 32'(busy), 32'd1);
      checkOutput("nto_we", 32'(we), 32'd0);
      checkOutput("nto_err", 32'(err_timeout), 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("nto_err_clr", 32'(err_timeout), 32'd0);
      finishFrame(1, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
